// File: rtl/uart_rx_fifo_pkg.sv
// Shared UART constants and helpers used by the receiver and the receive FIFO.
// Holds the byte width, the default FIFO depth and the occupancy-update encoding.
package uart_rx_fifo_pkg;

   localparam int UART_DW         = 8;
   localparam int UART_FIFO_DEPTH = 16;

   // Occupancy change produced by one cycle of write/pop activity.
   typedef enum logic [1:0] {
      CNT_HOLD = 2'b00,
      CNT_INC  = 2'b01,
      CNT_DEC  = 2'b10
   } cnt_op_e;

   function automatic bit is_pow2(input int value);
      return (value > 0) && ((value & (value - 1)) == 0);
   endfunction

   function automatic cnt_op_e cnt_op(input logic wr_en, input logic rd_en);
      cnt_op_e op;
      op = CNT_HOLD;
      if (wr_en && !rd_en) op = CNT_INC;
      else if (!wr_en && rd_en) op = CNT_DEC;
      return op;
   endfunction

endpackage

// File: rtl/uart_rx_fifo_ctrl.sv
// Pointer, occupancy and overflow control for the UART receive FIFO.
// Optional synchronous flush input when UART_RX_FIFO_FLUSH_EN is defined.
module uart_rx_fifo_ctrl
   import uart_rx_fifo_pkg::*;
#(
   parameter int AW = 4
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          locked,
   input  logic          wr_tick,
   input  logic          rd_pop,
   input  logic          ovf_clr,
`ifdef UART_RX_FIFO_FLUSH_EN
   input  logic          flush,
`endif
   output logic          wr_en,
   output logic [AW-1:0] wr_ptr,
   output logic [AW-1:0] rd_ptr,
   output logic [AW:0]   count,
   output logic          full,
   output logic          rd_valid,
   output logic          overflow
);

   localparam logic [AW-1:0] PTR_ONE  = {{(AW-1){1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_ONE  = {{AW{1'b0}}, 1'b1};
   localparam logic [AW:0]   CNT_FULL = {1'b1, {AW{1'b0}}};

   logic    rd_en;
   logic    ovf_set;
   cnt_op_e op;

   // Flags come straight from the registered count, so nothing on the write
   // side reaches the read side within the same cycle.
   assign full     = (count == CNT_FULL);
   assign rd_valid = (count != '0);

   // A pop on a full FIFO frees the slot the write needs in the same edge.
   assign wr_en   = wr_tick && locked && (!full || rd_pop);
   assign rd_en   = rd_pop && rd_valid;
   assign ovf_set = wr_tick && locked && full && !rd_pop;
   assign op      = cnt_op(wr_en, rd_en);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end
`ifdef UART_RX_FIFO_FLUSH_EN
      else if (flush) begin
         wr_ptr   <= '0;
         rd_ptr   <= '0;
         count    <= '0;
         overflow <= 1'b0;
      end
`endif
      else begin
         if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
         if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
         case (op)
            CNT_INC: count <= count + CNT_ONE;
            CNT_DEC: count <= count - CNT_ONE;
            default: count <= count;
         endcase
         // A dropped byte outranks a same-cycle clear so the loss is never hidden.
         if (ovf_set)      overflow <= 1'b1;
         else if (ovf_clr) overflow <= 1'b0;
      end
   end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receive byte FIFO: first-word-fall-through read side, sticky overflow.
// Define UART_RX_FIFO_FLUSH_EN to add the synchronous flush input.
module uart_rx_fifo
   import uart_rx_fifo_pkg::*;
#(
   parameter int DW    = UART_DW,
   parameter int DEPTH = UART_FIFO_DEPTH
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     locked,
   input  logic                     wr_tick,
   input  logic [DW-1:0]            wr_data,
   input  logic                     rd_pop,
   output logic [DW-1:0]            rd_data,
   output logic                     rd_valid,
   output logic                     full,
   output logic [$clog2(DEPTH):0]   count,
   output logic                     overflow,
   input  logic                     ovf_clr
`ifdef UART_RX_FIFO_FLUSH_EN
   ,
   input  logic                     flush
`endif
);

   localparam int AW = $clog2(DEPTH);

   if (!is_pow2(DEPTH) || DEPTH < 2) begin : g_bad_depth
      $error("uart_rx_fifo: DEPTH must be a power of two and at least 2");
   end

   logic [DW-1:0] mem [DEPTH];
   logic          wr_en;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;

   uart_rx_fifo_ctrl #(
      .AW (AW)
   ) u_ctrl (
      .clk      (clk),
      .reset    (reset),
      .locked   (locked),
      .wr_tick  (wr_tick),
      .rd_pop   (rd_pop),
      .ovf_clr  (ovf_clr),
`ifdef UART_RX_FIFO_FLUSH_EN
      .flush    (flush),
`endif
      .wr_en    (wr_en),
      .wr_ptr   (wr_ptr),
      .rd_ptr   (rd_ptr),
      .count    (count),
      .full     (full),
      .rd_valid (rd_valid),
      .overflow (overflow)
   );

   // Storage is intentionally not reset; the control block's count says what is live.
   always_ff @(posedge clk) begin
      if (wr_en) mem[wr_ptr] <= wr_data;
   end

   assign rd_data = rd_valid ? mem[rd_ptr] : '0;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Self-checking bench for uart_rx_fifo against a queue-based reference model.
// Covers the flush path as well when UART_RX_FIFO_FLUSH_EN is defined.
module tb_uart_rx_fifo;

   localparam int DEPTH = 16;

   logic       clk = 1'b0;
   logic       reset;
   logic       locked;
   logic       wr_tick;
   logic [7:0] wr_data;
   logic       rd_pop;
   logic [7:0] rd_data;
   logic       rd_valid;
   logic       full;
   logic [4:0] count;
   logic       overflow;
   logic       ovf_clr;
`ifdef UART_RX_FIFO_FLUSH_EN
   logic       flush;
`endif

   int checks   = 0;
   int failures = 0;

   byte unsigned q[$];
   bit           m_ovf;
   byte unsigned last_pop;

   always #5 clk = ~clk;

   uart_rx_fifo dut (
      .clk      (clk),
      .reset    (reset),
      .locked   (locked),
      .wr_tick  (wr_tick),
      .wr_data  (wr_data),
      .rd_pop   (rd_pop),
      .rd_data  (rd_data),
      .rd_valid (rd_valid),
      .full     (full),
      .count    (count),
      .overflow (overflow),
      .ovf_clr  (ovf_clr)
`ifdef UART_RX_FIFO_FLUSH_EN
      ,
      .flush    (flush)
`endif
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string tag);
      int unsigned head;
      head = (q.size() != 0) ? 32'(q[0]) : 0;
      check({tag, ".count"},    32'(count),    q.size());
      check({tag, ".rd_valid"}, 32'(rd_valid), (q.size() != 0) ? 1 : 0);
      check({tag, ".full"},     32'(full),     (q.size() == DEPTH) ? 1 : 0);
      check({tag, ".rd_data"},  32'(rd_data),  head);
      check({tag, ".overflow"}, 32'(overflow), 32'(m_ovf));
   endtask

   // One clock of stimulus: apply inputs, advance the model by the rules, compare after the edge.
   task automatic cycle(input string tag, input bit tk, input byte unsigned d, input bit pp,
                        input bit clr, input bit fl);
      bit do_pop, do_wr;
      wr_tick = tk; wr_data = d; rd_pop = pp; ovf_clr = clr;
`ifdef UART_RX_FIFO_FLUSH_EN
      flush = fl;
`endif
      do_pop = pp && (q.size() != 0);
      do_wr  = tk && locked && ((q.size() < DEPTH) || pp);
`ifdef UART_RX_FIFO_FLUSH_EN
      if (fl) begin
         q.delete();
         m_ovf = 1'b0;
      end else
`endif
      begin
         if (tk && locked && q.size() == DEPTH && !pp) m_ovf = 1'b1;
         else if (clr) m_ovf = 1'b0;
         if (do_pop) last_pop = q.pop_front();
         if (do_wr) q.push_back(d);
      end
      @(posedge clk);
      #1;
      wr_tick = 1'b0; rd_pop = 1'b0; ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_FLUSH_EN
      flush = 1'b0;
`endif
      check_all(tag);
   endtask

   task automatic do_reset(input string tag);
      @(negedge clk);
      reset = 1'b1;
      #2;
      q.delete();
      m_ovf = 1'b0;
      check_all({tag, ".async"});
      @(negedge clk);
      reset = 1'b0;
      #1;
      check_all(tag);
   endtask

   initial begin
      bit tk, pp, clr, fl;
      reset = 1'b0; locked = 1'b0; wr_tick = 1'b0; wr_data = '0; rd_pop = 1'b0; ovf_clr = 1'b0;
`ifdef UART_RX_FIFO_FLUSH_EN
      flush = 1'b0;
`endif
      m_ovf = 1'b0;
      last_pop = 0;
      #1;
      do_reset("reset");

      // 1: single byte through, then pop
      locked = 1'b1;
      cycle("t1.wr", 1, 8'h41, 0, 0, 0);
      check("t1.rd_data", 32'(rd_data), 32'h41);
      cycle("t1.pop", 0, 0, 1, 0, 0);
      check("t1.rd_valid", 32'(rd_valid), 0);

      // 2: writes ignored while unlocked
      locked = 1'b0;
      for (int i = 0; i < 3; i++) cycle("t2.unlocked", 1, 8'h55, 0, 0, 0);
      check("t2.count", 32'(count), 0);
      locked = 1'b1;

      // 3: fill, overflow, drain in order
      for (int i = 0; i < DEPTH; i++) cycle("t3.fill", 1, byte'(i), 0, 0, 0);
      check("t3.full", 32'(full), 1);
      cycle("t3.ovf", 1, 8'hAA, 0, 0, 0);
      check("t3.overflow", 32'(overflow), 1);
      check("t3.count", 32'(count), 16);
      cycle("t3.clr", 0, 0, 0, 1, 0);
      for (int i = 0; i < DEPTH; i++) begin
         check("t3.order", 32'(rd_data), i);
         cycle("t3.drain", 0, 0, 1, 0, 0);
      end

      // 4: write and pop together while full
      for (int i = 0; i < DEPTH; i++) cycle("t4.fill", 1, byte'(i), 0, 0, 0);
      cycle("t4.both", 1, 8'h77, 1, 0, 0);
      check("t4.count", 32'(count), 16);
      check("t4.head", 32'(rd_data), 1);
      check("t4.overflow", 32'(overflow), 0);
      for (int i = 0; i < DEPTH; i++) cycle("t4.drain", 0, 0, 1, 0, 0);
      check("t4.last", 32'(last_pop), 32'h77);

      // 5: pointer wrap with occupancy held at one
      cycle("t5.first", 1, byte'($urandom), 0, 0, 0);
      for (int i = 0; i < 40; i++) begin
         cycle("t5.pair", 1, byte'($urandom), 1, 0, 0);
         check("t5.count_le1", 32'(count <= 1), 1);
      end
      cycle("t5.last", 0, 0, 1, 0, 0);

      // 6: overflow set beats same-cycle clear
      for (int i = 0; i < DEPTH; i++) cycle("t6.fill", 1, byte'($urandom), 0, 0, 0);
      cycle("t6.ovf", 1, 8'hEE, 0, 0, 0);
      cycle("t6.set_clr", 1, 8'hEF, 0, 1, 0);
      check("t6.overflow_kept", 32'(overflow), 1);
      cycle("t6.clr", 0, 0, 0, 1, 0);
      check("t6.overflow_cleared", 32'(overflow), 0);
      locked = 1'b0;
      cycle("t6.unlocked_full", 1, 8'h12, 0, 0, 0);
      check("t6.no_ovf_unlocked", 32'(overflow), 0);
      locked = 1'b1;
      for (int i = 0; i < DEPTH; i++) cycle("t6.drain", 0, 0, 1, 0, 0);

`ifdef UART_RX_FIFO_FLUSH_EN
      for (int i = 0; i < 5; i++) cycle("t6.fill5", 1, byte'($urandom), 0, 0, 0);
      cycle("t6.flush", 1, 8'h99, 1, 0, 1);
      check("t6.flush_count", 32'(count), 0);
      check("t6.flush_valid", 32'(rd_valid), 0);
`endif

      // reset mid-stream discards content
      for (int i = 0; i < 6; i++) cycle("rst.fill", 1, byte'($urandom), 0, 0, 0);
      do_reset("rst.mid");
      locked = 1'b1;

      // random traffic
      for (int i = 0; i < 400; i++) begin
         locked = ($urandom_range(0, 3) != 0);
         tk  = $urandom_range(0, 1) == 1;
         pp  = (i < 200) ? ($urandom_range(0, 9) < 3) : ($urandom_range(0, 9) < 7);
         clr = $urandom_range(0, 9) == 0;
         fl  = 1'b0;
`ifdef UART_RX_FIFO_FLUSH_EN
         fl  = $urandom_range(0, 49) == 0;
`endif
         cycle("rand", tk, byte'($urandom), pp, clr, fl);
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
